// File: rtl/vend_pkg.sv
// Shared types and constants for the newspaper vending transaction controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  localparam int COIN_UNIT = 5;

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter shared by the coin-inactivity and dispense-ack timeouts.
module vend_timer #(
  parameter int LOAD_VAL = 1000,
  parameter int TW       = $clog2(LOAD_VAL + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TW'(LOAD_VAL);
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Terminal count fires on the edge that would take the count from 1 to 0.
  assign expired = en && !load && (cnt == TW'(1));

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin collection, dispense handshake, change payout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no credit, waiting for the first coin
// COLLECT  | partial credit, accepting coins, inactivity timer running
// DISPENSE | disp_req held, waiting for disp_ack or ack timeout
// CHANGE   | chg_req held, paying out credit in 5-point coins
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE       = 15,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CW          = $clog2(PRICE + 6)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    coin,
  input  logic          coin_valid,
  input  logic          cancel,
  input  logic          disp_ack,
  input  logic          chg_ack,
  output logic          coin_accept,
  output logic          coin_reject,
  output logic          disp_req,
  output logic          chg_req,
  output logic [CW-1:0] credit,
  output logic          busy,
  output logic          disp_err,
  output logic [15:0]   vend_count
);

  localparam logic [CW-1:0] C_PRICE = CW'(PRICE);
  localparam logic [CW-1:0] C_UNIT  = CW'(COIN_UNIT);

  state_t        state, state_nxt;
  logic          take;
  logic [CW-1:0] coin_val, credit_add, credit_left;
  logic          tmr_en, tmr_exp;

  always_comb begin
    take = coin_valid && (coin == COIN_5 || coin == COIN_10) &&
           (state == IDLE || (state == COLLECT && !cancel));
    coin_val    = (coin == COIN_10) ? CW'(2 * COIN_UNIT) : C_UNIT;
    credit_add  = credit + coin_val;
    credit_left = credit - C_PRICE;
    tmr_en      = (state == COLLECT) || (state == DISPENSE);
    state_nxt   = state;
    case (state)
      IDLE:
        if (take) state_nxt = (credit_add >= C_PRICE) ? DISPENSE : COLLECT;
      COLLECT:
        if (cancel)       state_nxt = CHANGE;
        else if (take)    state_nxt = (credit_add >= C_PRICE) ? DISPENSE : COLLECT;
        else if (tmr_exp) state_nxt = CHANGE;
      DISPENSE:
        if (disp_ack)     state_nxt = (credit_left != '0) ? CHANGE : IDLE;
        else if (tmr_exp) state_nxt = CHANGE;
      CHANGE:
        if (chg_ack && credit <= C_UNIT) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every accepted coin restarts the timer; this also covers the entry into DISPENSE.
  vend_timer #(.LOAD_VAL(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (take),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      coin_accept <= 1'b0;
      coin_reject <= 1'b0;
      disp_req    <= 1'b0;
      chg_req     <= 1'b0;
      credit      <= '0;
      busy        <= 1'b0;
      disp_err    <= 1'b0;
      vend_count  <= '0;
    end else begin
      state       <= state_nxt;
      coin_accept <= (state_nxt == IDLE) || (state_nxt == COLLECT);
      busy        <= (state_nxt != IDLE);
      disp_req    <= (state_nxt == DISPENSE);
      chg_req     <= (state_nxt == CHANGE);
      coin_reject <= coin_valid && !take;
      disp_err    <= (state == DISPENSE) && !disp_ack && tmr_exp;
      if (take) begin
        credit <= credit_add;
      end else if (state == DISPENSE && disp_ack) begin
        credit     <= credit_left;
        vend_count <= vend_count + 16'd1;
      end else if (state == CHANGE && chg_ack) begin
        credit <= credit - C_UNIT;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst)
    (int'(credit) <= PRICE + COIN_UNIT) && ((int'(credit) % COIN_UNIT) == 0));

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed plus randomized bench for vend_sequencer against a transaction-level model.
module tb_vend_sequencer;

  localparam int PRICE = 15;
  localparam int TMO   = 8;
  localparam int CW    = $clog2(PRICE + 6);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    coin = 2'b00;
  logic          coin_valid = 1'b0;
  logic          cancel = 1'b0;
  logic          disp_ack = 1'b0;
  logic          chg_ack = 1'b0;
  logic          coin_accept, coin_reject, disp_req, chg_req, busy, disp_err;
  logic [CW-1:0] credit;
  logic [15:0]   vend_count;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: phase 0 idle, 1 collecting, 2 awaiting dispenser, 3 paying change.
  int m_phase, m_credit, m_left, m_vends;
  bit m_fresh, m_reject, m_err;

  vend_sequencer #(.PRICE(PRICE), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .coin(coin), .coin_valid(coin_valid), .cancel(cancel),
    .disp_ack(disp_ack), .chg_ack(chg_ack), .coin_accept(coin_accept),
    .coin_reject(coin_reject), .disp_req(disp_req), .chg_req(chg_req),
    .credit(credit), .busy(busy), .disp_err(disp_err), .vend_count(vend_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_credit = 0; m_left = 0; m_vends = 0;
    m_fresh = 1; m_reject = 0; m_err = 0;
  endtask

  task automatic model_step(input bit cv, input int cn, input bit ca, input bit da, input bit ka);
    bit good;
    int val;
    good = cv && (cn == 1 || cn == 2) && (m_phase == 0 || (m_phase == 1 && !ca));
    val = (cn == 2) ? 10 : 5;
    m_fresh = 0;
    m_reject = cv && !good;
    m_err = 0;
    case (m_phase)
      0: if (good) begin
        m_credit += val; m_left = TMO;
        m_phase = (m_credit >= PRICE) ? 2 : 1;
      end
      1: if (ca) m_phase = 3;
         else if (good) begin
           m_credit += val; m_left = TMO;
           if (m_credit >= PRICE) m_phase = 2;
         end else begin
           m_left--;
           if (m_left == 0) m_phase = 3;
         end
      2: if (da) begin
           m_credit -= PRICE; m_vends++;
           m_phase = (m_credit > 0) ? 3 : 0;
         end else begin
           m_left--;
           if (m_left == 0) begin m_err = 1; m_phase = 3; end
         end
      default: if (ka) begin
           m_credit -= 5;
           if (m_credit == 0) m_phase = 0;
         end
    endcase
  endtask

  task automatic check_outputs();
    if (m_fresh) begin
      chk("coin_accept", coin_accept, 0); chk("coin_reject", coin_reject, 0);
      chk("disp_req", disp_req, 0);       chk("chg_req", chg_req, 0);
      chk("credit", credit, 0);           chk("busy", busy, 0);
      chk("disp_err", disp_err, 0);       chk("vend_count", vend_count, 0);
    end else begin
      chk("coin_accept", coin_accept, m_phase <= 1);
      chk("coin_reject", coin_reject, m_reject);
      chk("disp_req", disp_req, m_phase == 2);
      chk("chg_req", chg_req, m_phase == 3);
      chk("credit", credit, m_credit);
      chk("busy", busy, m_phase != 0);
      chk("disp_err", disp_err, m_err);
      chk("vend_count", vend_count, m_vends & 16'hFFFF);
    end
  endtask

  // Inputs are applied at a falling edge, latched at the next rising edge, outputs checked at the following fall.
  task automatic cyc(input bit cv, input int cn, input bit ca, input bit da, input bit ka);
    coin_valid = cv; coin = 2'(cn); cancel = ca; disp_ack = da; chg_ack = ka;
    @(posedge clk);
    model_step(cv, cn, ca, da, ka);
    @(negedge clk);
    coin_valid = 0; coin = 2'b00; cancel = 0; disp_ack = 0; chg_ack = 0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b1;

    // Exact sale: 5 then 10, ack on the third cycle of disp_req.
    cyc(1, 1, 0, 0, 0); cyc(1, 2, 0, 0, 0);
    idle(2); cyc(0, 0, 0, 1, 0); idle(1);
    chk("sale1_vends", vend_count, 1);

    // Overpay: 10 + 10, one change coin.
    cyc(1, 2, 0, 0, 0); cyc(1, 2, 0, 0, 0); idle(1);
    cyc(0, 0, 0, 1, 0); idle(1); cyc(0, 0, 0, 0, 1); idle(1);
    chk("sale2_credit", credit, 0);

    // Cancel after 5; then cancel colliding with a coin 10.
    cyc(1, 1, 0, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1); idle(1);
    cyc(1, 1, 0, 0, 0); cyc(1, 2, 1, 0, 0); idle(1); cyc(0, 0, 0, 0, 1); idle(1);

    // Coin during DISPENSE and invalid code in IDLE.
    cyc(1, 2, 0, 0, 0); cyc(1, 2, 0, 0, 0); cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1); cyc(1, 3, 0, 0, 0); idle(1);

    // Dispenser never acks: error then three refund coins.
    cyc(1, 1, 0, 0, 0); cyc(1, 2, 0, 0, 0); idle(TMO + 1);
    for (int i = 0; i < 3; i++) begin cyc(0, 0, 0, 0, 1); idle(1); end
    chk("tmo_credit", credit, 0);

    // Inactivity refund.
    cyc(1, 1, 0, 0, 0); idle(TMO + 1); cyc(0, 0, 0, 0, 1); idle(1);

    // Asynchronous reset while paying change.
    cyc(1, 2, 0, 0, 0); cyc(1, 2, 0, 0, 0); cyc(0, 0, 0, 1, 0); idle(1);
    chk("pre_rst_chg_req", chg_req, 1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 2) == 0), $urandom_range(0, 3), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
